// File: rtl/prbs_checker.sv
// Self-synchronizing PRBS checker: flags per-bit errors against the received history,
// tracks lock with clean/errored run counters and accumulates errors while locked.
module prbs_checker #(
  parameter int unsigned               LFSR_WIDTH   = 31,
  parameter logic [LFSR_WIDTH-1:0]     LFSR_POLY    = 31'h10000001,
  parameter int unsigned               DATA_WIDTH   = 8,
  parameter int unsigned               LOCK_COUNT   = 16,
  parameter int unsigned               UNLOCK_COUNT = 4,
  parameter int unsigned               COUNT_WIDTH  = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [DATA_WIDTH-1:0]  in_data,
  input  logic                   in_valid,
  input  logic                   clear,
  output logic [DATA_WIDTH-1:0]  err_bits,
  output logic                   err_valid,
  output logic                   locked,
  output logic [COUNT_WIDTH-1:0] err_count
);

  localparam int unsigned LockW   = $clog2(LOCK_COUNT + 1);
  localparam int unsigned UnlockW = $clog2(UNLOCK_COUNT + 1);
  localparam int unsigned PopW    = $clog2(DATA_WIDTH + 1);
  localparam int unsigned SumW    = (COUNT_WIDTH > PopW) ? COUNT_WIDTH + 1 : PopW + 1;

  typedef enum logic {StUnlocked, StLocked} state_e;

  state_e                 state_q;
  logic [LFSR_WIDTH-1:0]  hist_q, hist_d;
  logic [LockW-1:0]       clean_run_q;
  logic [UnlockW-1:0]     err_run_q;
  logic [DATA_WIDTH-1:0]  err_bits_q;
  logic                   err_valid_q;
  logic                   locked_q;
  logic [COUNT_WIDTH-1:0] err_count_q;

  logic [DATA_WIDTH-1:0]  word_err;
  logic                   pred;
  logic [PopW-1:0]        word_pop;
  logic [SumW-1:0]        count_sum;
  logic [COUNT_WIDTH-1:0] count_inc;
  logic                   word_clean;

  // Walk the word MSB first; history always absorbs the received bit, never the prediction.
  always_comb begin
    hist_d   = hist_q;
    word_err = '0;
    pred     = 1'b0;
    for (int i = DATA_WIDTH - 1; i >= 0; i--) begin
      pred = hist_d[LFSR_WIDTH-1];
      for (int j = 1; j < LFSR_WIDTH; j++) begin
        if (LFSR_POLY[j]) pred = pred ^ hist_d[j-1];
      end
      word_err[i] = in_data[i] ^ pred;
      hist_d      = {hist_d[LFSR_WIDTH-2:0], in_data[i]};
    end
  end

  always_comb begin
    word_pop = '0;
    for (int i = 0; i < DATA_WIDTH; i++) begin
      word_pop = word_pop + PopW'(word_err[i]);
    end
    count_sum  = SumW'(err_count_q) + SumW'(word_pop);
    count_inc  = (count_sum > SumW'({COUNT_WIDTH{1'b1}})) ? '1 : count_sum[COUNT_WIDTH-1:0];
    // An all-zero history matches any all-zero stream and must not earn lock.
    word_clean = (word_err == '0) && (hist_d != '0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StUnlocked;
      hist_q      <= '0;
      clean_run_q <= '0;
      err_run_q   <= '0;
      err_bits_q  <= '0;
      err_valid_q <= 1'b0;
      locked_q    <= 1'b0;
      err_count_q <= '0;
    end else begin
      err_valid_q <= in_valid;
      if (in_valid) begin
        hist_q     <= hist_d;
        err_bits_q <= word_err;
        unique case (state_q)
          StUnlocked: begin
            if (!word_clean) begin
              clean_run_q <= '0;
            end else if (clean_run_q == LockW'(LOCK_COUNT - 1)) begin
              state_q     <= StLocked;
              locked_q    <= 1'b1;
              clean_run_q <= '0;
            end else begin
              clean_run_q <= clean_run_q + 1'b1;
            end
          end
          StLocked: begin
            err_count_q <= count_inc;
            if (word_err == '0) begin
              err_run_q <= '0;
            end else if (err_run_q == UnlockW'(UNLOCK_COUNT - 1)) begin
              state_q   <= StUnlocked;
              locked_q  <= 1'b0;
              err_run_q <= '0;
            end else begin
              err_run_q <= err_run_q + 1'b1;
            end
          end
          default: ;
        endcase
      end
      // Later assignment wins over a same-cycle increment.
      if (clear) err_count_q <= '0;
    end
  end

  assign err_bits  = err_bits_q;
  assign err_valid = err_valid_q;
  assign locked    = locked_q;
  assign err_count = err_count_q;

endmodule

// File: tb/tb_prbs_checker.sv
// Bench for prbs_checker: PRBS7 stimulus against a bit-stream reference model.
module tb_prbs_checker;
  localparam int unsigned LW = 7;
  localparam logic [6:0]  POLY = 7'h41;
  localparam int unsigned DW = 8;
  localparam int          LOCK_N = 16;
  localparam int          UNLOCK_N = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic in_valid = 1'b0;
  logic clear = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic [7:0] err_bits, err_bits4;
  logic err_valid, err_valid4, locked, locked4;
  logic [31:0] err_count;
  logic [3:0] err_count4;

  always #5 clk = ~clk;

  prbs_checker #(.LFSR_WIDTH(7), .LFSR_POLY(7'h41), .DATA_WIDTH(8), .LOCK_COUNT(16),
                 .UNLOCK_COUNT(4), .COUNT_WIDTH(32)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .clear(clear),
    .err_bits(err_bits), .err_valid(err_valid), .locked(locked), .err_count(err_count)
  );

  prbs_checker #(.LFSR_WIDTH(7), .LFSR_POLY(7'h41), .DATA_WIDTH(8), .LOCK_COUNT(16),
                 .UNLOCK_COUNT(4), .COUNT_WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .clear(clear),
    .err_bits(err_bits4), .err_valid(err_valid4), .locked(locked4), .err_count(err_count4)
  );

  int total = 0;
  int bad = 0;

  // Reference model: the full received bit stream, oldest first, preceded by LW zeros.
  bit         stream[$];
  int         m_clean_run, m_err_run, m_count4;
  bit         m_locked;
  longint     m_count;
  logic [7:0] m_err_bits;
  bit   [6:0] gen;

  function automatic void model_reset();
    stream.delete();
    for (int k = 0; k < LW; k++) stream.push_back(1'b0);
    m_clean_run = 0; m_err_run = 0; m_locked = 0;
    m_count = 0; m_count4 = 0; m_err_bits = 8'h00;
  endfunction

  // Bit received k+1 bits ago is h[k]; prediction follows the tap rule on that stream.
  function automatic bit predict();
    int n = stream.size();
    bit p = stream[n-LW];
    for (int j = 1; j < LW; j++) if (POLY[j]) p = p ^ stream[n-j];
    return p;
  endfunction

  function automatic void model_word(input logic [7:0] w, input bit clr);
    logic [7:0] e = 8'h00;
    bit nz = 0;
    int pc;
    for (int i = DW - 1; i >= 0; i--) begin
      e[i] = w[i] ^ predict();
      stream.push_back(w[i]);
    end
    for (int k = 1; k <= LW; k++) nz = nz | stream[stream.size()-k];
    pc = $countones(e);
    if (m_locked) begin
      m_count  = (m_count + pc > 64'hFFFF_FFFF) ? 64'hFFFF_FFFF : m_count + pc;
      m_count4 = (m_count4 + pc > 15) ? 15 : m_count4 + pc;
      if (e != 0) begin
        m_err_run++;
        if (m_err_run == UNLOCK_N) begin m_locked = 0; m_err_run = 0; end
      end else m_err_run = 0;
    end else begin
      if (e == 0 && nz) begin
        m_clean_run++;
        if (m_clean_run == LOCK_N) begin m_locked = 1; m_clean_run = 0; end
      end else m_clean_run = 0;
    end
    if (clr) begin m_count = 0; m_count4 = 0; end
    m_err_bits = e;
  endfunction

  // PRBS7 generator x^7+x^6+1, MSB of each word transmitted first.
  function automatic logic [7:0] next_prbs();
    logic [7:0] w = 8'h00;
    bit b;
    for (int i = 7; i >= 0; i--) begin
      b = gen[6] ^ gen[5];
      gen = {gen[5:0], b};
      w[i] = b;
    end
    return w;
  endfunction

  task automatic send(input logic [7:0] w, input bit clr);
    in_data = w; in_valid = 1'b1; clear = clr;
    model_word(w, clr);
    @(posedge clk); #1;
    in_valid = 1'b0; clear = 1'b0;
  endtask

  task automatic idle(input bit clr);
    in_valid = 1'b0; clear = clr;
    if (clr) begin m_count = 0; m_count4 = 0; end
    @(posedge clk); #1;
    clear = 1'b0;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    model_reset();
    gen = 7'h7F;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic lock_up();
    repeat (20) send(next_prbs(), 1'b0);
  endtask

  task automatic test_reset();
    #3 rst = 1'b1;
    #1;
    total++;
    if (err_bits !== 8'h00 || err_valid !== 1'b0 || locked !== 1'b0 || err_count !== 32'h0
        || err_count4 !== 4'h0) begin
      bad++;
      $display("FAIL reset_state: got bits=%h v=%b lk=%b cnt=%0d cnt4=%0d want all zero",
               err_bits, err_valid, locked, err_count, err_count4);
    end
    @(posedge clk); #1 rst = 1'b0;
    model_reset();
  endtask

  task automatic test_lock();
    int dut_at = -1, mod_at = -1;
    apply_reset();
    for (int k = 1; k <= 20; k++) begin
      send(next_prbs(), 1'b0);
      total++;
      if (err_valid !== 1'b1 || err_bits !== m_err_bits || locked !== m_locked) begin
        bad++;
        $display("FAIL lock_word %0d: got v=%b bits=%h lk=%b want v=1 bits=%h lk=%b",
                 k, err_valid, err_bits, locked, m_err_bits, m_locked);
      end
      if (locked === 1'b1 && dut_at < 0) dut_at = k;
      if (m_locked && mod_at < 0) mod_at = k;
    end
    total++;
    if (dut_at != mod_at) begin
      bad++;
      $display("FAIL lock_index: got word %0d want word %0d", dut_at, mod_at);
    end
    total++;
    if (err_bits !== 8'h00 || err_count !== 32'h0 || locked !== 1'b1) begin
      bad++;
      $display("FAIL lock_final: got bits=%h cnt=%0d lk=%b want 00 0 1", err_bits, err_count, locked);
    end
  endtask

  task automatic test_single_flip();
    logic [7:0] mask;
    int s;
    mask = 8'h01 << $urandom_range(0, 7);
    send(next_prbs() ^ mask, 1'b0);
    s = $countones(err_bits);
    total++;
    if (err_bits !== m_err_bits) begin
      bad++;
      $display("FAIL flip_word0: got %h want %h", err_bits, m_err_bits);
    end
    send(next_prbs(), 1'b0);
    s += $countones(err_bits);
    total++;
    if (err_bits !== m_err_bits) begin
      bad++;
      $display("FAIL flip_word1: got %h want %h", err_bits, m_err_bits);
    end
    repeat (2) send(next_prbs(), 1'b0);
    total++;
    if (s != 3 || err_count !== 32'd3 || locked !== 1'b1) begin
      bad++;
      $display("FAIL flip_total: got bits=%0d cnt=%0d lk=%b want 3 3 1", s, err_count, locked);
    end
  endtask

  task automatic test_unlock();
    int s = 0;
    apply_reset();
    lock_up();
    for (int k = 1; k <= 4; k++) begin
      send(8'hFF, 1'b0);
      s += $countones(err_bits);
      total++;
      if (locked !== (k < 4) || locked !== m_locked || err_bits !== m_err_bits) begin
        bad++;
        $display("FAIL unlock_word %0d: got lk=%b bits=%h want lk=%b bits=%h",
                 k, locked, err_bits, m_locked, m_err_bits);
      end
    end
    total++;
    if (err_count !== 32'(m_count) || err_count !== 32'(s)) begin
      bad++;
      $display("FAIL unlock_count: got %0d want %0d (popcount sum %0d)", err_count, m_count, s);
    end
  endtask

  task automatic test_all_zero();
    apply_reset();
    for (int k = 1; k <= 40; k++) begin
      send(8'h00, 1'b0);
      total++;
      if (locked !== 1'b0 || err_bits !== 8'h00) begin
        bad++;
        $display("FAIL zero_word %0d: got lk=%b bits=%h want 0 00", k, locked, err_bits);
      end
    end
  endtask

  task automatic test_clear();
    apply_reset();
    lock_up();
    send(next_prbs() ^ 8'h10, 1'b0);
    send(next_prbs(), 1'b0);
    total++;
    if (err_count !== 32'(m_count) || m_count == 0) begin
      bad++;
      $display("FAIL clear_pre: got %0d want %0d", err_count, m_count);
    end
    send(next_prbs() ^ 8'h80, 1'b1);
    total++;
    if (err_count !== 32'h0 || err_bits !== m_err_bits || err_bits == 8'h00) begin
      bad++;
      $display("FAIL clear_collide: got cnt=%0d bits=%h want 0 %h", err_count, err_bits, m_err_bits);
    end
    send(next_prbs(), 1'b0);
    total++;
    if (err_count !== 32'(m_count) || locked !== 1'b1) begin
      bad++;
      $display("FAIL clear_post: got cnt=%0d lk=%b want %0d 1", err_count, locked, m_count);
    end
    idle(1'b1);
    total++;
    if (err_count !== 32'h0 || locked !== 1'b1) begin
      bad++;
      $display("FAIL clear_idle: got cnt=%0d lk=%b want 0 1", err_count, locked);
    end
  endtask

  task automatic test_saturate();
    apply_reset();
    lock_up();
    for (int k = 0; k < 7; k++) begin
      send(next_prbs() ^ (8'h01 << k), 1'b0);
      repeat (2) send(next_prbs(), 1'b0);
    end
    total++;
    if (err_count4 !== 4'hF || err_count4 !== 4'(m_count4) || locked4 !== 1'b1) begin
      bad++;
      $display("FAIL sat_count4: got %0d lk=%b want 15 1", err_count4, locked4);
    end
    total++;
    if (err_count !== 32'(m_count) || m_count != 21) begin
      bad++;
      $display("FAIL sat_count32: got %0d want %0d", err_count, m_count);
    end
  endtask

  task automatic test_reset_relock();
    int dut_at = -1, mod_at = -1;
    apply_reset();
    lock_up();
    for (int k = 0; k < 3; k++) begin
      send(next_prbs() ^ 8'h04, 1'b0);
      idle(1'b0);
      total++;
      if (err_valid !== 1'b0 || err_bits !== m_err_bits || locked !== 1'b1) begin
        bad++;
        $display("FAIL gap_hold %0d: got v=%b bits=%h lk=%b want 0 %h 1",
                 k, err_valid, err_bits, locked, m_err_bits);
      end
    end
    in_data = next_prbs(); in_valid = 1'b1;
    #2 rst = 1'b1;
    #1;
    total++;
    if (err_bits !== 8'h00 || err_valid !== 1'b0 || locked !== 1'b0 || err_count !== 32'h0
        || err_count4 !== 4'h0 || locked4 !== 1'b0) begin
      bad++;
      $display("FAIL midword_reset: got bits=%h v=%b lk=%b cnt=%0d want all zero",
               err_bits, err_valid, locked, err_count);
    end
    model_reset();
    @(posedge clk); #1 in_valid = 1'b0;
    @(posedge clk); #1 rst = 1'b0;
    for (int k = 1; k <= 24; k++) begin
      send(next_prbs(), 1'b0);
      if (k % 5 == 0) idle(1'b0);
      total++;
      if (locked !== m_locked || err_bits !== m_err_bits) begin
        bad++;
        $display("FAIL relock_word %0d: got lk=%b bits=%h want lk=%b bits=%h",
                 k, locked, err_bits, m_locked, m_err_bits);
      end
      if (locked === 1'b1 && dut_at < 0) dut_at = k;
      if (m_locked && mod_at < 0) mod_at = k;
    end
    total++;
    if (dut_at != mod_at || mod_at < 0) begin
      bad++;
      $display("FAIL relock_index: got word %0d want word %0d", dut_at, mod_at);
    end
  endtask

  task automatic test_random();
    logic [7:0] w;
    bit clr, sent;
    apply_reset();
    for (int it = 0; it < 400; it++) begin
      clr = ($urandom_range(0, 15) == 0);
      sent = ($urandom_range(0, 9) > 1);
      if (sent) begin
        w = next_prbs();
        if ($urandom_range(0, 11) == 0) w = w ^ (8'h01 << $urandom_range(0, 7));
        if ($urandom_range(0, 59) == 0) w = 8'($urandom);
        send(w, clr);
      end else idle(clr);
      total++;
      if (err_valid !== sent || err_bits !== m_err_bits || locked !== m_locked
          || err_count !== 32'(m_count) || err_count4 !== 4'(m_count4)
          || err_bits4 !== m_err_bits || locked4 !== m_locked || err_valid4 !== sent) begin
        bad++;
        $display("FAIL random %0d: got v=%b bits=%h lk=%b cnt=%0d c4=%0d want %b %h %b %0d %0d",
                 it, err_valid, err_bits, locked, err_count, err_count4,
                 sent, m_err_bits, m_locked, m_count, m_count4);
      end
    end
  endtask

  initial begin
    test_reset();
    test_lock();
    test_single_flip();
    test_unlock();
    test_all_zero();
    test_clear();
    test_saturate();
    test_reset_relock();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
